// File: rtl/sprite_ctrl.sv
// Sprite engine: bounding-box hit test, ROM addressing, two-stage pixel
// pipeline with black-as-transparent keying, and a once-per-frame motion FSM
// that moves the sprite from the buttons with screen-edge clamping.
module sprite_ctrl #(
  parameter int          SPR_W      = 10,
  parameter int          SPR_H      = 20,
  parameter int          SCALE_LOG2 = 1,
  parameter int          H_MAX      = 640,
  parameter int          V_MAX      = 480,
  parameter int          STEP       = 2,
  parameter int          X_INIT     = 100,
  parameter int          Y_INIT     = 50,
  parameter logic [11:0] BG_RGB     = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [4:0]  rom_row,
  output logic [3:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic [11:0] rgb_out,
  output logic        sprite_on,
  output logic [9:0]  spr_x,
  output logic [9:0]  spr_y,
  output logic [1:0]  dbg_state
);

  localparam int SW    = SPR_W << SCALE_LOG2;
  localparam int SH    = SPR_H << SCALE_LOG2;
  localparam int X_MAX = H_MAX - SW;
  localparam int Y_MAX = V_MAX - SH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPD_X = 2'd1,
    UPD_Y = 2'd2
  } state_t;

  state_t      r_state;
  logic [9:0]  r_spr_x;
  logic [9:0]  r_spr_y;
  logic        r_hit_d1;
  logic        r_von_d1;
  logic [11:0] r_rgb;
  logic        r_sprite_on;

  // Box edges are formed at 11 bits so spr + size can never wrap.
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_hit;
  logic [9:0]  w_dx;
  logic [9:0]  w_dy;

  assign w_x_end = {1'b0, r_spr_x} + 11'(SW);
  assign w_y_end = {1'b0, r_spr_y} + 11'(SH);
  assign w_hit   = (pixel_x >= r_spr_x) && ({1'b0, pixel_x} < w_x_end) &&
                   (pixel_y >= r_spr_y) && ({1'b0, pixel_y} < w_y_end);
  assign w_dx    = pixel_x - r_spr_x;
  assign w_dy    = pixel_y - r_spr_y;

  // ROM address is combinational; forced to 0 outside the box.
  assign rom_col = w_hit ? 4'(w_dx >> SCALE_LOG2) : 4'd0;
  assign rom_row = w_hit ? 5'(w_dy >> SCALE_LOG2) : 5'd0;

  // Candidate next positions, clamped to the legal range.
  logic [10:0] w_x_inc;
  logic [10:0] w_y_inc;
  logic [9:0]  w_x_right;
  logic [9:0]  w_x_left;
  logic [9:0]  w_y_down;
  logic [9:0]  w_y_up;

  assign w_x_inc   = {1'b0, r_spr_x} + 11'(STEP);
  assign w_y_inc   = {1'b0, r_spr_y} + 11'(STEP);
  assign w_x_right = (w_x_inc > 11'(X_MAX)) ? 10'(X_MAX) : w_x_inc[9:0];
  assign w_y_down  = (w_y_inc > 11'(Y_MAX)) ? 10'(Y_MAX) : w_y_inc[9:0];
  assign w_x_left  = (r_spr_x < 10'(STEP)) ? 10'd0 : r_spr_x - 10'(STEP);
  assign w_y_up    = (r_spr_y < 10'(STEP)) ? 10'd0 : r_spr_y - 10'(STEP);

  // Motion FSM: one x step then one y step per frame_tick, ticks ignored while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_spr_x <= 10'(X_INIT);
      r_spr_y <= 10'(Y_INIT);
    end else begin
      case (r_state)
        IDLE: begin
          if (frame_tick) r_state <= UPD_X;
        end
        UPD_X: begin
          if (btn_right && !btn_left)      r_spr_x <= w_x_right;
          else if (btn_left && !btn_right) r_spr_x <= w_x_left;
          r_state <= UPD_Y;
        end
        UPD_Y: begin
          if (btn_down && !btn_up)      r_spr_y <= w_y_down;
          else if (btn_up && !btn_down) r_spr_y <= w_y_up;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pixel pipeline: stage 1 aligns hit/video_on with rom_data, stage 2 keys and registers colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_d1    <= 1'b0;
      r_von_d1    <= 1'b0;
      r_rgb       <= 12'h000;
      r_sprite_on <= 1'b0;
    end else begin
      r_hit_d1 <= w_hit;
      r_von_d1 <= video_on;
      if (!r_von_d1) begin
        r_rgb       <= 12'h000;
        r_sprite_on <= 1'b0;
      end else if (r_hit_d1 && (rom_data != 12'h000)) begin
        r_rgb       <= rom_data;
        r_sprite_on <= 1'b1;
      end else begin
        r_rgb       <= BG_RGB;
        r_sprite_on <= 1'b0;
      end
    end
  end

  assign rgb_out   = r_rgb;
  assign sprite_on = r_sprite_on;
  assign spr_x     = r_spr_x;
  assign spr_y     = r_spr_y;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sprite_ctrl.sv
// Directed bench for sprite_ctrl with a registered colour ROM model.
module tb_sprite_ctrl;

  logic        clk;
  logic        reset;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        frame_tick;
  logic        btn_left;
  logic        btn_right;
  logic        btn_up;
  logic        btn_down;
  logic [4:0]  rom_row;
  logic [3:0]  rom_col;
  logic [11:0] rom_data;
  logic [11:0] rgb_out;
  logic        sprite_on;
  logic [9:0]  spr_x;
  logic [9:0]  spr_y;
  logic [1:0]  dbg_state;

  int total  = 0;
  int passed = 0;

  sprite_ctrl dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
    .rgb_out(rgb_out), .sprite_on(sprite_on), .spr_x(spr_x), .spr_y(spr_y),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM image: (0,0)=FFF, odd columns black, others {row[3:0], col, A}.
  function automatic logic [11:0] rom_img(input logic [4:0] r, input logic [3:0] c);
    if (r == 5'd0 && c == 4'd0) return 12'hFFF;
    if (c[0]) return 12'h000;
    return {r[3:0], c, 4'hA};
  endfunction

  always @(posedge clk) rom_data <= rom_img(rom_row, rom_col);

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Present a pixel, check the same-cycle address, then the output 2 edges later.
  task automatic pix(input string tag, input int x, input int y, input logic von,
                     input logic [4:0] exp_row, input logic [3:0] exp_col,
                     input logic [11:0] exp_rgb, input logic exp_on);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    #1;
    chk({tag, "_row"}, 12'(rom_row), 12'(exp_row));
    chk({tag, "_col"}, 12'(rom_col), 12'(exp_col));
    cycles(2);
    chk({tag, "_rgb"}, rgb_out, exp_rgb);
    chk({tag, "_on"}, 12'(sprite_on), 12'(exp_on));
  endtask

  // One frame tick then enough cycles for UPD_X and UPD_Y to finish.
  task automatic tick();
    frame_tick = 1'b1;
    cycles(1);
    frame_tick = 1'b0;
    cycles(3);
  endtask

  initial begin
    reset = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(1);

    // reset asserted while FSM is in UPD_X takes effect without a clock edge
    btn_right  = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    chk("pre_rst_state", 12'(dbg_state), 12'd1);
    reset = 1'b1;
    #1;
    chk("rst_state", 12'(dbg_state), 12'd0);
    chk("rst_x", 12'(spr_x), 12'd100);
    chk("rst_y", 12'(spr_y), 12'd50);
    chk("rst_rgb", rgb_out, 12'h000);
    chk("rst_on", 12'(sprite_on), 12'd0);
    btn_right = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(1);
    chk("post_rst_x", 12'(spr_x), 12'd100);

    // pixel path with sprite at (100,50)
    pix("hit00",  100, 50, 1'b1, 5'd0,  4'd0, 12'hFFF, 1'b1);
    pix("transp", 102, 50, 1'b1, 5'd0,  4'd1, 12'h000, 1'b0);
    pix("hit12",  104, 52, 1'b1, 5'd1,  4'd2, 12'h12A, 1'b1);
    pix("corner", 117, 89, 1'b1, 5'd19, 4'd8, 12'h38A, 1'b1);
    pix("miss_r", 120, 50, 1'b1, 5'd0,  4'd0, 12'h000, 1'b0);
    pix("miss_l",  99, 50, 1'b1, 5'd0,  4'd0, 12'h000, 1'b0);
    pix("miss_b", 100, 90, 1'b1, 5'd0,  4'd0, 12'h000, 1'b0);
    pix("vidoff", 100, 50, 1'b0, 5'd0,  4'd0, 12'h000, 1'b0);

    // motion
    btn_right = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("right3_x", 12'(spr_x), 12'd106);
    chk("right3_y", 12'(spr_y), 12'd50);
    btn_left = 1'b1;
    tick();
    chk("both_x", 12'(spr_x), 12'd106);
    btn_left = 1'b0; btn_right = 1'b0; btn_down = 1'b1;
    tick();
    chk("down_y", 12'(spr_y), 12'd52);
    chk("down_x", 12'(spr_x), 12'd106);
    btn_down = 1'b0;

    // sprite moved: old origin now misses, new origin hits
    pix("moved_old", 100, 50, 1'b1, 5'd0, 4'd0, 12'h000, 1'b0);
    pix("moved_new", 106, 52, 1'b1, 5'd0, 4'd0, 12'hFFF, 1'b1);

    // frame_tick on consecutive cycles gives a single step
    btn_right  = 1'b1;
    frame_tick = 1'b1;
    cycles(2);
    frame_tick = 1'b0;
    cycles(3);
    chk("dbl_tick_x", 12'(spr_x), 12'd108);
    chk("dbl_tick_state", 12'(dbg_state), 12'd0);

    // right edge clamp at H_MAX - SW = 620
    for (int i = 0; i < 255; i++) tick();
    chk("at_618", 12'(spr_x), 12'd618);
    tick();
    chk("clamp_620a", 12'(spr_x), 12'd620);
    tick();
    chk("clamp_620b", 12'(spr_x), 12'd620);
    pix("edge_hit", 639, 52, 1'b1, 5'd0, 4'd9, 12'h000, 1'b0);
    pix("edge_hit2", 638, 54, 1'b1, 5'd1, 4'd9, 12'h000, 1'b0);
    btn_right = 1'b0;

    // top edge clamp at 0
    btn_up = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    chk("at_y2", 12'(spr_y), 12'd2);
    tick();
    chk("clamp_y0a", 12'(spr_y), 12'd0);
    tick();
    chk("clamp_y0b", 12'(spr_y), 12'd0);
    btn_up = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sprite_ctrl.md
Name: sprite_ctrl

Overview:
Sprite engine that sits between the VGA sync/pixel generator and the 12-bit sprite colour ROM (20 rows x 10 cols, 5-bit row / 4-bit col address, address registered inside the ROM). Each pixel clock it tests the current scan coordinate against the sprite's bounding box and drives the ROM address. It pipelines the hit flag to match ROM latency, applies black-as-transparent keying and outputs the final RGB. Once per frame it runs a small FSM that moves the sprite from button inputs, with screen-edge clamping.

Parameters:
SPR_W, 10, sprite width in ROM columns
SPR_H, 20, sprite height in ROM rows
SCALE_LOG2, 1, pixel replication factor 2^SCALE_LOG2 in x and y
H_MAX, 640, visible width in pixels
V_MAX, 480, visible height in pixels
STEP, 2, pixels moved per frame per held direction
X_INIT, 100, reset x position (top-left)
Y_INIT, 50, reset y position (top-left)
BG_RGB, 12'h000, colour output when in video but not on an opaque sprite pixel

Ports:
clk  in  1  system/pixel clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
pixel_x  in  10  current scan column
pixel_y  in  10  current scan row
video_on  in  1  high in visible area
frame_tick  in  1  one-cycle pulse at start of vertical blank
btn_left, btn_right, btn_up, btn_down  in  1 each  debounced level inputs
rom_row  out  5  ROM row address, combinational from pixel_y/spr_y
rom_col  out  4  ROM column address, combinational from pixel_x/spr_x
rom_data  in  12  ROM colour, valid 1 cycle after address presented
rgb_out  out  12  registered pixel colour
sprite_on  out  1  registered, high when rgb_out is an opaque sprite pixel
spr_x  out  10  current sprite x position
spr_y  out  10  current sprite y position

Behaviour:
- Reset (async): spr_x=X_INIT, spr_y=Y_INIT, FSM=IDLE, rgb_out=0, sprite_on=0, pipeline regs=0.
- Bounding box: SW = SPR_W<<SCALE_LOG2, SH = SPR_H<<SCALE_LOG2.
- hit = pixel_x>=spr_x, pixel_x<spr_x+SW, pixel_y>=spr_y, pixel_y<spr_y+SH. Compute the sums at 11 bits so they cannot overflow.
- rom_col = (pixel_x-spr_x)>>SCALE_LOG2 and rom_row = (pixel_y-spr_y)>>SCALE_LOG2 when hit. Both are 0 when not hit.
- Stage 1 registers hit and video_on (hit_d1, von_d1). These align with rom_data.
- Stage 2 registers the output:
  - if !von_d1: rgb_out=0, sprite_on=0.
  - else if hit_d1 and rom_data!=12'h000: rgb_out=rom_data, sprite_on=1.
  - else: rgb_out=BG_RGB, sprite_on=0.
- Latency: a coordinate presented in cycle t is reflected on rgb_out/sprite_on after the rising edge ending cycle t+1 (2 edges). Throughput is 1 pixel/clk with no stalls.
- Motion FSM states: IDLE, UPD_X, UPD_Y.
  - IDLE -> UPD_X on frame_tick. frame_tick in any other state is ignored.
  - UPD_X, one cycle:
    - right only: spr_x = min(spr_x+STEP, H_MAX-SW)
    - left only: spr_x = (spr_x<STEP) ? 0 : spr_x-STEP
    - both or neither: unchanged
    - -> UPD_Y
  - UPD_Y, one cycle: same rule with down/up and V_MAX-SH, then -> IDLE.
- Position changes only in UPD_X/UPD_Y, i.e. during vblank. Position never leaves [0,H_MAX-SW] x [0,V_MAX-SH].
- The pixel pipeline keeps running during FSM states and uses the current spr_x/spr_y.
- Reset asserted mid-FSM or mid-pipeline immediately forces all reset values; no partial update survives.

Test Plan:
- Reset: assert reset with FSM in UPD_X -> spr_x=100, spr_y=50, rgb_out=0, sprite_on=0, FSM=IDLE immediately, without waiting for a clock edge.
- Opaque hit: spr=(100,50), SCALE_LOG2=1, video_on=1, pixel=(100,50) -> rom_row=0, rom_col=0 same cycle. 2 edges later rgb_out=12'hFFF, sprite_on=1.
- Transparency/miss:
  - pixel (102,50) -> rom_col=1 (ROM 000) -> rgb_out=BG_RGB, sprite_on=0.
  - pixel (120,50) -> outside box -> rom_row/col=0, sprite_on=0.
  - video_on=0 -> rgb_out=0.
- Motion: btn_right held, 3 frame_ticks -> spr_x=106. btn_left+btn_right held -> spr_x unchanged. btn_down 1 tick -> spr_y=52.
- Clamp: spr_x=618, btn_right, 2 ticks -> 620 then 620. spr_y=1, btn_up -> 0.
- Tick during update: frame_tick on consecutive cycles -> only one step applied.
